// File: rtl/ps2_pad_decoder_if.sv
// Bundles the raw GPIO pad inputs and the decoded per-controller button outputs.
interface ps2_pad_decoder_if #(
    parameter int unsigned CODE_W  = 4,
    parameter int unsigned NUM_BTN = 10,
    parameter int unsigned SEL_W   = 1
);
    localparam int unsigned NUM_CTRL = 32'(1) << SEL_W;
    localparam int unsigned OUT_W    = NUM_CTRL * NUM_BTN;

    logic [CODE_W-1:0] code_in;
    logic [SEL_W-1:0]  sel_in;
    logic [OUT_W-1:0]  buttons;
    logic [OUT_W-1:0]  press_pulse;
    logic              code_err;

    modport master (
        output code_in, sel_in,
        input  buttons, press_pulse, code_err
    );

    modport slave (
        input  code_in, sel_in,
        output buttons, press_pulse, code_err
    );
endinterface

// File: rtl/ps2_pad_decoder.sv
// Synchronises and debounces the {select, code} GPIO bus, then commits it into
// per-controller one-hot button vectors with press pulses and a bad-code pulse.
module ps2_pad_decoder #(
    parameter int unsigned CODE_W        = 4,
    parameter int unsigned NUM_BTN       = 10,
    parameter int unsigned SEL_W         = 1,
    parameter int unsigned STABLE_CYCLES = 500000
) (
    input  logic              clock,
    input  logic              reset,
    ps2_pad_decoder_if.slave  bus
);
    localparam int unsigned NUM_CTRL = 32'(1) << SEL_W;
    localparam int unsigned OUT_W    = NUM_CTRL * NUM_BTN;
    localparam int unsigned IN_W     = SEL_W + CODE_W;
    localparam int unsigned CNT_W    = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_LATCHED = 2'd2
    } state_t;

    state_t             r_state;
    logic [IN_W-1:0]    r_sync1;
    logic [IN_W-1:0]    r_s;
    logic [IN_W-1:0]    r_s_prev;
    logic [CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]   r_buttons;
    logic [OUT_W-1:0]   r_press;
    logic               r_err;

    logic [SEL_W-1:0]   w_sel;
    logic [CODE_W-1:0]  w_code;
    logic               w_stable;
    logic               w_code_bad;
    logic [NUM_BTN-1:0] w_slice;
    logic [OUT_W-1:0]   w_new_buttons;

    assign w_sel      = r_s[IN_W-1 -: SEL_W];
    assign w_code     = r_s[CODE_W-1:0];
    assign w_stable   = (r_s == r_s_prev);
    assign w_code_bad = (32'(w_code) > NUM_BTN);

    // Button vector that a commit of the current synchronised value would produce
    always_comb begin
        w_slice = '0;
        for (int b = 0; b < int'(NUM_BTN); b++) begin
            w_slice[b] = (32'(w_code) == 32'(b + 1));
        end
        w_new_buttons = r_buttons;
        if (!w_code_bad) begin
            w_new_buttons[32'(w_sel) * NUM_BTN +: NUM_BTN] = w_slice;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sync1   <= '0;
            r_s       <= '0;
            r_s_prev  <= '0;
            r_cnt     <= '0;
            r_buttons <= '0;
            r_press   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_sync1  <= {bus.sel_in, bus.code_in};
            r_s      <= r_sync1;
            r_s_prev <= r_s;
            r_press  <= '0;
            r_err    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_stable) begin
                        r_state <= ST_COUNT;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                ST_COUNT: begin
                    if (!w_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        // Stable long enough: commit once, then wait for the next change
                        r_buttons <= w_new_buttons;
                        r_press   <= w_new_buttons & ~r_buttons;
                        r_err     <= w_code_bad;
                        r_state   <= ST_LATCHED;
                    end else if (r_cnt != CNT_W'(STABLE_CYCLES)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_LATCHED: begin
                    if (!w_stable) begin
                        r_state <= ST_COUNT;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.buttons     = r_buttons;
    assign bus.press_pulse = r_press;
    assign bus.code_err    = r_err;
endmodule
